mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Memory-side responder for the cache request interface: accepts instruction-fetch and data read/write requests from the cache block and serialises them onto a single-ported RAM.
- Returns load data and per-port wait handshakes.
- Sits between caches and the RAM model.
- Data port has priority, with round-robin fairness so instruction fetch is never starved.

Parameters:
- WORD_W, 32, width of addresses and data words
- TIMEOUT, 255, max cycles to wait for ram_ack (used only with MEM_ARB_TIMEOUT_EN); counter width is clog2(TIMEOUT+1)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, synchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  WORD_W  instruction address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  data write value
- iwait  out  1  low for exactly one cycle when the instruction request completes
- iload  out  WORD_W  instruction data, valid while iwait=0
- dwait  out  1  low for exactly one cycle when the data request completes
- dload  out  WORD_W  read data, valid while dwait=0
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data, valid with ram_ack
- ram_ack  in  1  RAM access complete (one-cycle pulse)
- err  out  1  timeout completion flag; tied 0 without the optional feature

Behaviour:
- Reset (nRST=0 at posedge) puts the block in this state:
  - state IDLE
  - iwait=1, dwait=1
  - iload=0, dload=0
  - ram* outputs 0, err=0
  - last_grant=I, so D wins the first contention
  - Reset mid-access abandons the access with no completion pulse.
- States: IDLE, D_ACC, I_ACC, D_DONE, I_DONE.
- Arbitration in IDLE:
  - Data pending (dREN|dWEN) and instruction idle -> D_ACC.
  - Instruction pending and data idle -> I_ACC.
  - Both pending -> grant the port opposite to last_grant. last_grant updates on entry to an ACC state.
- D_ACC:
  - ramaddr=daddr (live, requester holds it stable).
  - dWEN=1 -> ramWEN=1, ramstore=dstore.
  - dWEN=0 -> ramREN=1.
  - dREN&dWEN both high is treated as a write.
  - On ram_ack: capture ramload into the dload register (reads only; writes leave dload unchanged) -> D_DONE.
- I_ACC:
  - ramREN=1, ramaddr=iaddr.
  - On ram_ack: capture ramload into iload -> I_DONE.
- D_DONE / I_DONE:
  - The matching wait is 0 for this single cycle; all ram strobes are 0.
  - Next state is IDLE unconditionally, so a held request re-arbitrates next cycle.
- Waits are 1 in every state except the matching DONE state. Waits are registered-state decoded, with no combinational path from request inputs.
- Withdrawal: if the granted request drops (dREN|dWEN=0, or iREN=0) while in ACC before ram_ack -> IDLE, no wait pulse, load register unchanged.
- Withdrawal and ram_ack in the same cycle: withdrawal wins, no pulse.
- ram_ack in IDLE or DONE is ignored.
- Latency: with ram_ack arriving N cycles after the strobe rises (N>=0, same-cycle allowed), the wait pulse occurs N+1 cycles after grant.
- Minimum turnaround is 3 cycles per access: ACC, DONE, IDLE.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to each ACC state and increments each ACC cycle.
  - If the count reaches TIMEOUT without ram_ack, the access completes as if acked: load register <= 32'hBAD1BAD1 for reads (writes unchanged), go to DONE, err=1 for that DONE cycle only.
  - err=0 otherwise; the counter saturates, never wraps.
- Undefined: no counter; ACC waits indefinitely; err tied 0.

Test Plan:
- Reset, then iREN=1, iaddr=0x100; ram_ack 2 cycles later with ramload=0x3C010001 -> ramREN=1, ramaddr=0x100; iwait=0 for exactly one cycle with iload=0x3C010001; dwait stays 1.
- dWEN=1, daddr=0x200, dstore=0xDEADBEEF; same-cycle ram_ack -> ramWEN=1, ramstore=0xDEADBEEF in D_ACC; dwait low 1 cycle later; dload unchanged at 0.
- iREN and dREN held high continuously, ack every cycle -> grants alternate D, I, D, I; first grant is D; neither port has two consecutive completions.
- dREN high, withdrawn after 1 ACC cycle with ram_ack coinciding -> no dwait pulse; dload unchanged; state IDLE next.
- nRST=0 asserted mid I_ACC -> next cycle iwait=1, ramREN=0, iload=0; a later ram_ack produces no pulse.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=4, dREN=1 and no ack -> dwait low at cycle 5 after grant; dload=0xBAD1BAD1; err=1 same cycle only.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and data requests onto one RAM port.
// Data wins contention unless it was granted last; a port is never granted twice
// in a row while the other is waiting.
// Optional build macro: MEM_ARB_TIMEOUT_EN adds an access watchdog. When it times
// out, the access completes with load value 32'hBAD1BAD1 and err is raised.
module mem_arbiter #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ack,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, D_ACC, I_ACC, D_DONE, I_DONE} state_t;

  state_t            state, state_next;
  logic              last_i, last_i_next;   // 1: instruction port held the last grant
  logic [WORD_W-1:0] iload_q, iload_next;
  logic [WORD_W-1:0] dload_q, dload_next;
  logic              d_req, i_req, withdraw, timeout_hit;

  assign d_req    = dREN | dWEN;
  assign i_req    = iREN;
  assign withdraw = ((state == D_ACC) && !d_req) || ((state == I_ACC) && !i_req);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] acc_cnt;
  logic             err_q;
  logic             in_acc;

  assign in_acc      = (state == D_ACC) || (state == I_ACC);
  assign timeout_hit = in_acc && (acc_cnt == CNT_W'(TIMEOUT));

  // Cycles spent in the current access; held at zero outside ACC so each access starts fresh.
  always_ff @(posedge CLK) begin
    if (!nRST)                          acc_cnt <= '0;
    else if (!in_acc)                   acc_cnt <= '0;
    else if (acc_cnt != CNT_W'(TIMEOUT)) acc_cnt <= acc_cnt + CNT_W'(1);
  end

  // Flag a DONE cycle that was reached by timeout rather than by ram_ack.
  always_ff @(posedge CLK) begin
    if (!nRST) err_q <= 1'b0;
    else       err_q <= timeout_hit && !ram_ack && !withdraw;
  end

  assign err = err_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // State, grant history and load registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      last_i  <= 1'b1;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state   <= state_next;
      last_i  <= last_i_next;
      iload_q <= iload_next;
      dload_q <= dload_next;
    end
  end

  // Arbitration, access sequencing and RAM strobes.
  always_comb begin
    state_next  = state;
    last_i_next = last_i;
    iload_next  = iload_q;
    dload_next  = dload_q;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || last_i)) begin
          state_next  = D_ACC;
          last_i_next = 1'b0;
        end else if (i_req) begin
          state_next  = I_ACC;
          last_i_next = 1'b1;
        end
      end
      D_ACC: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = 1'b1;
        end
        if (withdraw) begin
          state_next = IDLE;
        end else if (ram_ack) begin
          if (!dWEN) dload_next = ramload;
          state_next = D_DONE;
        end else if (timeout_hit) begin
          if (!dWEN) dload_next = WORD_W'(32'hBAD1BAD1);
          state_next = D_DONE;
        end
      end
      I_ACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (withdraw) begin
          state_next = IDLE;
        end else if (ram_ack) begin
          iload_next = ramload;
          state_next = I_DONE;
        end else if (timeout_hit) begin
          iload_next = WORD_W'(32'hBAD1BAD1);
          state_next = I_DONE;
        end
      end
      D_DONE:  state_next = IDLE;
      I_DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign iwait = (state != I_DONE);
  assign dwait = (state != D_DONE);
  assign iload = iload_q;
  assign dload = dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam int TO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         nRST, iREN, dREN, dWEN, ram_ack;
  logic [W-1:0] iaddr, daddr, dstore, ramload;
  logic         iwait, dwait, ramREN, ramWEN, err;
  logic [W-1:0] iload, dload, ramaddr, ramstore;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.WORD_W(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .iload(iload), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ack(ram_ack), .err(err)
  );

  always #5 CLK = ~CLK;

  // Reference model: which port owns the RAM, which port completes this cycle.
  int           owner;       // 0 none, 1 data, 2 instruction
  int           finishing;   // port whose completion is visible this cycle
  bit           fin_timeout;
  bit           last_was_i;
  int           spent;       // access cycles already used by the current owner
  logic [W-1:0] m_iload, m_dload;
  bit           model_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit           held, expired, dr;
    logic [W-1:0] v;
    if (!nRST) begin
      owner = 0; finishing = 0; fin_timeout = 1'b0; last_was_i = 1'b1;
      spent = 0; m_iload = '0; m_dload = '0; model_valid = 1'b1;
    end else if (model_valid) begin
      if (finishing != 0) begin
        finishing   = 0;
        fin_timeout = 1'b0;
      end else if (owner == 0) begin
        dr = dREN | dWEN;
        if (dr && iREN)  owner = last_was_i ? 1 : 2;
        else if (dr)     owner = 1;
        else if (iREN)   owner = 2;
        if (owner != 0) begin
          last_was_i = (owner == 2);
          spent      = 0;
        end
      end else begin
        held    = (owner == 1) ? (dREN | dWEN) : iREN;
        expired = TO_ON && (spent >= TO);
        if (!held) begin
          owner = 0;
        end else if (ram_ack || expired) begin
          v = ram_ack ? ramload : 32'hBAD1BAD1;
          if (owner == 2)   m_iload = v;
          else if (!dWEN)   m_dload = v;
          finishing   = owner;
          fin_timeout = !ram_ack;
          owner       = 0;
        end else begin
          spent++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic         e_ren, e_wen;
    logic [W-1:0] e_addr, e_store;
    e_ren   = (owner == 2) || (owner == 1 && !dWEN);
    e_wen   = (owner == 1) && dWEN;
    e_addr  = (owner == 1) ? daddr : (owner == 2) ? iaddr : '0;
    e_store = (owner == 1 && dWEN) ? dstore : '0;
    chk("iwait",    iwait,    finishing != 2);
    chk("dwait",    dwait,    finishing != 1);
    chk("iload",    iload,    m_iload);
    chk("dload",    dload,    m_dload);
    chk("ramREN",   ramREN,   e_ren);
    chk("ramWEN",   ramWEN,   e_wen);
    chk("ramaddr",  ramaddr,  e_addr);
    chk("ramstore", ramstore, e_store);
    chk("err",      err,      (finishing != 0) && fin_timeout);
  endtask

  // One clock: compare current outputs, take the edge, advance the model.
  task automatic cycle();
    #1;
    if (model_valid) check_outputs();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           ncomp;
    logic [31:0]  exp_port;
    logic [W-1:0] saved;

    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ack = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    @(posedge CLK); #1;
    cycle(); cycle();
    nRST = 1'b1;
    #1;
    chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 1);
    chk("rst_iload", iload, 0); chk("rst_dload", dload, 0);
    chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0); chk("rst_ramstore", ramstore, 0);
    chk("rst_err", err, 0);

    // Instruction fetch, ack two cycles after the strobe rises.
    iREN = 1'b1; iaddr = 32'h100;
    cycle();
    #1;
    chk("t1_ramREN", ramREN, 1); chk("t1_ramaddr", ramaddr, 32'h100);
    cycle(); cycle();
    ram_ack = 1'b1; ramload = 32'h3C010001;
    cycle();
    ram_ack = 1'b0; iREN = 1'b0;
    chk("t1_iwait", iwait, 0); chk("t1_iload", iload, 32'h3C010001);
    chk("t1_dwait", dwait, 1);
    cycle();
    chk("t1_iwait_after", iwait, 1);

    // Data write with same-cycle ack.
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    cycle();
    ram_ack = 1'b1; ramload = 32'h12345678;
    #1;
    chk("t2_ramWEN", ramWEN, 1); chk("t2_ramstore", ramstore, 32'hDEADBEEF);
    chk("t2_ramREN", ramREN, 0);
    cycle();
    ram_ack = 1'b0; dWEN = 1'b0;
    chk("t2_dwait", dwait, 0); chk("t2_dload", dload, 0);
    cycle();

    // Continuous contention after reset: completions alternate D, I, D, I.
    nRST = 1'b0; cycle(); nRST = 1'b1;
    dREN = 1'b1; iREN = 1'b1; ram_ack = 1'b1; ramload = 32'hA5A50001;
    ncomp = 0; exp_port = 0;
    for (int k = 0; k < 12; k++) begin
      ramload = $urandom;
      cycle();
      if (!dwait || !iwait) begin
        chk("alt_port", {31'b0, !iwait}, exp_port);
        exp_port = exp_port ^ 32'd1;
        ncomp++;
      end
    end
    chk("alt_count", ncomp, 4);
    dREN = 1'b0; iREN = 1'b0; ram_ack = 1'b0;
    cycle(); cycle();

    // Data read withdrawn in the same cycle as ram_ack.
    saved = m_dload;
    dREN = 1'b1;
    cycle(); cycle();
    dREN = 1'b0; ram_ack = 1'b1; ramload = 32'h0BADF00D;
    cycle();
    ram_ack = 1'b0;
    chk("wd_dwait", dwait, 1); chk("wd_dload", dload, saved);
    chk("wd_ramREN", ramREN, 0);
    cycle();
    chk("wd_dwait2", dwait, 1);

    // Reset in the middle of an instruction access.
    iREN = 1'b1;
    cycle(); cycle();
    nRST = 1'b0;
    cycle();
    nRST = 1'b1; iREN = 1'b0;
    chk("mr_iwait", iwait, 1); chk("mr_ramREN", ramREN, 0);
    chk("mr_iload", iload, 0);
    ram_ack = 1'b1;
    cycle();
    ram_ack = 1'b0;
    chk("mr_iwait2", iwait, 1);
    cycle();
    chk("mr_iwait3", iwait, 1);

`ifdef MEM_ARB_TIMEOUT_EN
    // Read with no ack completes by timeout.
    dREN = 1'b1;
    cycle();
    repeat (5) cycle();
    chk("to_dwait", dwait, 0); chk("to_dload", dload, 32'hBAD1BAD1);
    chk("to_err", err, 1);
    dREN = 1'b0;
    cycle();
    chk("to_err_after", err, 0); chk("to_dwait_after", dwait, 1);
`endif

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(7) == 0) iREN = ~iREN;
      if ($urandom_range(7) == 0) begin
        dREN = 1'($urandom_range(1));
        dWEN = 1'($urandom_range(1));
      end
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      ram_ack = ($urandom_range(2) == 0);
      nRST    = ($urandom_range(199) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
